uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
Packet parser and ALU sitting between the UART receiver and UART transmitter in the ice40 UART-ALU top.
- Consumes the receiver's AXI-Stream byte output and decodes framed command packets.
- Computes echo, 32-bit add or 32-bit multiply.
- Streams the response bytes into the transmitter's AXI-Stream input, honouring backpressure on both sides.

Parameters:
OP_ECHO, 8'hEC, opcode: echo the payload bytes.
OP_ADD, 8'hA0, opcode: 32-bit sum of the operands.
OP_MUL, 8'hA1, opcode: 32-bit product of the operands (only with ALU_MUL_EN).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
s_axis_tdata  input  8  byte from uart_rx
s_axis_tvalid  input  1  byte valid
s_axis_tready  output  1  byte accepted when tvalid & tready
m_axis_tdata  output  8  byte to uart_tx
m_axis_tvalid  output  1  output byte valid
m_axis_tready  input  1  uart_tx ready
error_o  output  1  one-cycle pulse: unknown opcode detected

Behaviour:
- Interface is decided: one clock, clk; reset rst, synchronous, active-high.
- Packet format:
  - Byte 0: opcode.
  - Byte 1: reserved, ignored.
  - Bytes 2/3: LEN, little-endian 16-bit total packet length including the 4-byte header.
  - Payload is LEN-4 bytes. If LEN<4, payload is 0.
- Reset: state=S_OPCODE; s_axis_tready=1; m_axis_tvalid=0; m_axis_tdata=0; error_o=0; accumulator, byte and length counters cleared. Reset mid-packet drops all partial state; the next accepted byte is an opcode.
- States and transitions:
  - S_OPCODE, S_RSV, S_LEN_LO, S_LEN_HI: tready=1; each accepted byte advances one state.
  - Leaving S_LEN_HI:
    - Echo opcode -> S_ECHO.
    - Add/mul opcode -> S_OPERAND. Accumulator=0 for add, 1 for mul.
    - Unknown opcode -> S_DRAIN, with error_o high for exactly that cycle.
    - Echo or drain with payload 0 -> S_OPCODE.
    - Arithmetic with payload 0 -> S_SEND.
  - S_ECHO: combinational pass-through.
    - m_axis_tdata=s_axis_tdata; m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready.
    - Counts transfers; after LEN-4 transfers -> S_OPCODE.
  - S_OPERAND: tready=1.
    - Collects bytes little-endian into a 32-bit operand.
    - On the 4th byte of a word: add -> accumulator+=operand in the same clock edge; mul -> S_MUL.
    - Trailing bytes (payload mod 4) are consumed and ignored.
    - Payload exhausted -> S_SEND. If the last byte completes a mul word, go to S_MUL first, then S_SEND.
  - S_MUL: tready=0. Shift-add multiply, exactly 32 cycles. Then -> S_OPERAND, or -> S_SEND if payload is exhausted.
  - S_SEND: tready=0; m_axis_tvalid=1.
    - Emits accumulator bytes [7:0],[15:8],[23:16],[31:24].
    - Each byte holds stable until m_axis_tready. After the 4th handshake -> S_OPCODE.
  - S_DRAIN: tready=1. Discards LEN-4 bytes; nothing is emitted. Then -> S_OPCODE.
- Arithmetic: all results are modulo 2^32; carries and upper product bits are discarded.
- m_axis_tvalid is 0 in every state except S_ECHO and S_SEND.
- Latency:
  - First result byte is valid the cycle after the final payload byte is accepted (add).
  - For mul, it is 33 cycles after the final byte of a word-completing operand.
- Back-to-back packets: an opcode byte may be accepted the cycle after the last response handshake.

Optional Feature:
ALU_MUL_EN
- Defined: OP_MUL is supported, along with the S_MUL state and the iterative multiplier.
- Undefined: no multiplier logic is built. OP_MUL is treated as an unknown opcode: error_o pulses and the payload is drained with no response.

Test Plan:
- Echo: EC 00 06 00 68 69 -> output 68 69; no further bytes; error_o never high.
- Add with wrap: A0 00 0C 00 FF FF FF FF 02 00 00 00 -> output 01 00 00 00.
- Multiply with ALU_MUL_EN: A1 00 0C 00 03 00 00 00 05 00 00 00 -> output 0F 00 00 00, first byte 33 cycles after the last input byte. Without the macro: error_o single pulse and no output.
- Unknown opcode: 55 00 06 00 AA BB -> error_o pulses once, zero output bytes. A following echo packet EC 00 05 00 7E -> output 7E.
- Backpressure: add packet with m_axis_tready held low 10 cycles per byte -> m_axis_tdata stable while tvalid is high; exactly 4 bytes; s_axis_tready=0 throughout S_SEND.
- Reset mid-packet: assert rst after A0 00 0C 00 01 -> all outputs at reset values. Then EC 00 05 00 41 -> output 41 only.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// Packet parser and ALU between uart_rx and uart_tx: echo, 32-bit add and, with ALU_MUL_EN
// defined, a 32-cycle shift-add multiply. Without ALU_MUL_EN, OP_MUL is an unknown opcode.
module uart_alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       error_o
);

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;

  typedef enum logic [3:0] {
    S_OPCODE, S_RSV, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPERAND, S_MUL, S_SEND, S_DRAIN
  } state_t;

  state_t      state, state_next;
  logic [7:0]  opcode;
  logic [7:0]  len_lo;
  logic [15:0] rem;
  logic [31:0] acc;
  logic [23:0] operand;
  logic [1:0]  idx;
`ifdef ALU_MUL_EN
  logic [31:0] mul_a, mul_b;
  logic [4:0]  mul_cnt;
`endif

  // A byte moves on either stream only in a cycle where tvalid and tready are both high;
  // the sender holds tdata stable from the cycle tvalid rises until that handshake.
  logic        s_fire, m_fire, last_byte, is_add, is_mul_op, is_echo;
  logic [15:0] len_full, pay_len;
  logic [31:0] word;

  always_comb begin
    s_fire    = s_axis_tvalid & s_axis_tready;
    m_fire    = m_axis_tvalid & m_axis_tready;
    len_full  = {s_axis_tdata, len_lo};
    pay_len   = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;
    word      = {s_axis_tdata, operand};
    last_byte = (rem == 16'd1);
    is_echo   = (opcode == OP_ECHO);
    is_add    = (opcode == OP_ADD);
`ifdef ALU_MUL_EN
    is_mul_op = (opcode == OP_MUL);
`else
    is_mul_op = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_OPCODE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    case (state)
      S_OPCODE: begin
        s_axis_tready = 1'b1;
        if (s_fire) state_next = S_RSV;
      end
      S_RSV: begin
        s_axis_tready = 1'b1;
        if (s_fire) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        s_axis_tready = 1'b1;
        if (s_fire) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        s_axis_tready = 1'b1;
        if (s_fire) begin
          if (is_echo)                state_next = (pay_len == 16'd0) ? S_OPCODE : S_ECHO;
          else if (is_add || is_mul_op) state_next = (pay_len == 16'd0) ? S_SEND : S_OPERAND;
          else                        state_next = (pay_len == 16'd0) ? S_OPCODE : S_DRAIN;
        end
      end
      S_ECHO: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (m_fire && last_byte) state_next = S_OPCODE;
      end
      S_OPERAND: begin
        s_axis_tready = 1'b1;
        if (s_fire) begin
          if (is_mul_op && idx == 2'd3) state_next = S_MUL;
          else if (last_byte)           state_next = S_SEND;
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (mul_cnt == 5'd31) state_next = (rem == 16'd0) ? S_SEND : S_OPERAND;
      end
`endif
      S_SEND: begin
        m_axis_tvalid = 1'b1;
        case (idx)
          2'd0:    m_axis_tdata = acc[7:0];
          2'd1:    m_axis_tdata = acc[15:8];
          2'd2:    m_axis_tdata = acc[23:16];
          default: m_axis_tdata = acc[31:24];
        endcase
        if (m_fire && idx == 2'd3) state_next = S_OPCODE;
      end
      S_DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_fire && last_byte) state_next = S_OPCODE;
      end
      default: state_next = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode  <= 8'h00;
      len_lo  <= 8'h00;
      rem     <= 16'd0;
      acc     <= 32'd0;
      operand <= 24'd0;
      idx     <= 2'd0;
      error_o <= 1'b0;
`ifdef ALU_MUL_EN
      mul_a   <= 32'd0;
      mul_b   <= 32'd0;
      mul_cnt <= 5'd0;
`endif
    end else begin
      error_o <= 1'b0;
      case (state)
        S_OPCODE: if (s_fire) opcode <= s_axis_tdata;
        S_LEN_LO: if (s_fire) len_lo <= s_axis_tdata;
        S_LEN_HI: if (s_fire) begin
          rem     <= pay_len;
          idx     <= 2'd0;
          acc     <= {31'd0, is_mul_op};
          error_o <= !(is_echo || is_add || is_mul_op);
        end
        S_ECHO:  if (m_fire) rem <= rem - 16'd1;
        S_DRAIN: if (s_fire) rem <= rem - 16'd1;
        S_OPERAND: if (s_fire) begin
          // Operand bytes shift in from the top so the word is little-endian when complete.
          rem     <= rem - 16'd1;
          operand <= {s_axis_tdata, operand[23:8]};
          idx     <= (state_next == S_SEND) ? 2'd0 : idx + 2'd1;
          if (idx == 2'd3) begin
`ifdef ALU_MUL_EN
            if (is_mul_op) begin
              mul_a   <= acc;
              mul_b   <= word;
              mul_cnt <= 5'd0;
              acc     <= 32'd0;
            end else begin
              acc <= acc + word;
            end
`else
            acc <= acc + word;
`endif
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          acc     <= acc + (mul_b[0] ? mul_a : 32'd0);
          mul_a   <= {mul_a[30:0], 1'b0};
          mul_b   <= {1'b0, mul_b[31:1]};
          mul_cnt <= mul_cnt + 5'd1;
        end
`endif
        S_SEND: if (m_fire) idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: packets are modelled at byte/word level, expected response
// bytes are queued, and a negedge monitor pops and compares every output handshake.
module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_tready;
  logic       error_o;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  uart_alu_ctrl dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_tready),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];
  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int err_exp = 0;
  int rdy_mode = 0;
  int bp_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink readiness: always ready, random, or low for 10 cycles per high cycle.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = ($urandom_range(0, 3) != 0);
        default: begin
          bp_cnt   = (bp_cnt + 1) % 11;
          m_tready = (bp_cnt == 10);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (error_o) err_seen++;
      if (stall_prev) begin
        check("stall_valid_held", {31'd0, m_axis_tvalid}, 32'd1);
        check("stall_data_stable", {24'd0, m_axis_tdata}, {24'd0, stall_data});
      end
      if (m_axis_tvalid && !s_tvalid)
        check("send_s_tready_low", {31'd0, s_axis_tready}, 32'd0);
      if (m_axis_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'd0, m_axis_tdata}, 32'hFFFF_FFFF);
        else check("out_byte", {24'd0, m_axis_tdata}, {24'd0, exp_q.pop_front()});
      end
      stall_prev = m_axis_tvalid && !m_tready;
      stall_data = m_axis_tdata;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n;
    s_tdata = b; s_tvalid = 1'b1; ok = 1'b0; n = 0;
    while (!ok && n < 3000) begin
      @(negedge clk); ok = s_axis_tready;
      @(posedge clk); #1; n++;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0;
  endtask

  // Reference model: response derived from opcode, LEN and little-endian payload words.
  task automatic model_and_send();
    int len, pay;
    int unsigned r, w;
    logic [7:0] op;
    op  = pkt[0];
    len = int'(pkt[2]) + 256 * int'(pkt[3]);
    pay = (len < 4) ? 0 : len - 4;
    if (op == 8'hEC) begin
      for (int i = 0; i < pay; i++) exp_q.push_back(pkt[4 + i]);
    end else if (op == 8'hA0 || (op == 8'hA1 && MUL_EN)) begin
      r = (op == 8'hA0) ? 0 : 1;
      for (int k = 0; k < pay / 4; k++) begin
        w = {pkt[4+4*k+3], pkt[4+4*k+2], pkt[4+4*k+1], pkt[4+4*k]};
        r = (op == 8'hA0) ? r + w : r * w;
      end
      exp_q.push_back(r[7:0]);   exp_q.push_back(r[15:8]);
      exp_q.push_back(r[23:16]); exp_q.push_back(r[31:24]);
    end else begin
      err_exp++;
    end
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  task automatic build(input logic [7:0] op, input int len);
    pkt = {};
    pkt.push_back(op); pkt.push_back(8'($urandom));
    pkt.push_back(len[7:0]); pkt.push_back(len[15:8]);
    for (int i = 4; i < len; i++) pkt.push_back(8'($urandom));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); n++; end
    check(name, exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic latency(input string name, input int exp_cycles);
    int n = 0;
    do begin @(negedge clk); n++; end while (!m_axis_tvalid && n < 100);
    check(name, n, exp_cycles);
  endtask

  initial begin
    logic [7:0] op;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_error", {31'd0, error_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h68, 8'h69};
    model_and_send();
    wait_idle("echo_drain");

    pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    model_and_send();
    latency("add_latency", 1);
    wait_idle("add_drain");

    pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    model_and_send();
`ifdef ALU_MUL_EN
    latency("mul_latency", 33);
`endif
    wait_idle("mul_drain");
    check("mul_err_count", err_seen, err_exp);

    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    model_and_send();
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    model_and_send();
    wait_idle("unknown_drain");
    check("unknown_err_count", err_seen, err_exp);

    rdy_mode = 2;
    build(8'hA0, 16);
    model_and_send();
    wait_idle("backpressure_drain");
    rdy_mode = 0;

    foreach (pkt[i]) pkt.delete(i);
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00); send_byte(8'h01);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check("midrst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("midrst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("midrst_error", {31'd0, error_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h41};
    model_and_send();
    wait_idle("midrst_echo_drain");

    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(0, 3))
        0: op = 8'hEC;
        1: op = 8'hA0;
        2: op = 8'hA1;
        default: begin
          op = 8'($urandom);
          if (op == 8'hEC || op == 8'hA0 || op == 8'hA1) op = 8'h00;
        end
      endcase
      build(op, $urandom_range(0, 24));
      model_and_send();
    end
    wait_idle("random_drain");
    rdy_mode = 0;
    check("final_err_count", err_seen, err_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
